// File: rtl/exu_longp_sched_pkg.sv
// Shared widths, unit encodings and the OITF entry layout for the long-pipe
// write-back scheduler.
package exu_longp_sched_pkg;

  localparam int XLEN              = 32;
  localparam int RFIDX_WIDTH       = 5;
  localparam int LONGP_OITF_DEPTH  = 4;
  localparam int LONGP_ITAG_WIDTH  = 2;

  typedef enum logic {
    LONGP_UNIT_LSU = 1'b0,
    LONGP_UNIT_MDV = 1'b1
  } longp_unit_e;

  typedef struct packed {
    longp_unit_e             unit;
    logic                    rdwen;
    logic [RFIDX_WIDTH-1:0]  rdidx;
  } oitf_entry_t;

endpackage

// File: rtl/exu_longp_sched_if.sv
// Dispatch, unit write-back and arbiter-side signals of the long-pipe scheduler.
interface exu_longp_sched_if #(
  parameter int ITAG_W = 2
);
  import exu_longp_sched_pkg::*;

  logic                    disp_i_valid;
  logic                    disp_i_ready;
  logic                    disp_i_unit;
  logic                    disp_i_rdwen;
  logic [RFIDX_WIDTH-1:0]  disp_i_rdidx;
  logic [ITAG_W-1:0]       disp_o_itag;
  logic                    oitf_empty;

  logic                    lsu_wbck_i_valid;
  logic                    lsu_wbck_i_ready;
  logic [XLEN-1:0]         lsu_wbck_i_wdat;
  logic [ITAG_W-1:0]       lsu_wbck_i_itag;

  logic                    mdv_wbck_i_valid;
  logic                    mdv_wbck_i_ready;
  logic [XLEN-1:0]         mdv_wbck_i_wdat;
  logic [ITAG_W-1:0]       mdv_wbck_i_itag;

  logic                    longp_wbck_o_valid;
  logic                    longp_wbck_o_ready;
  logic [XLEN-1:0]         longp_wbck_o_wdat;
  logic [RFIDX_WIDTH-1:0]  longp_wbck_o_rdidx;

  modport master (
    output disp_i_valid, disp_i_unit, disp_i_rdwen, disp_i_rdidx,
    input  disp_i_ready, disp_o_itag, oitf_empty,
    output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_itag,
    input  lsu_wbck_i_ready,
    output mdv_wbck_i_valid, mdv_wbck_i_wdat, mdv_wbck_i_itag,
    input  mdv_wbck_i_ready,
    input  longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx,
    output longp_wbck_o_ready
  );

  modport slave (
    input  disp_i_valid, disp_i_unit, disp_i_rdwen, disp_i_rdidx,
    output disp_i_ready, disp_o_itag, oitf_empty,
    input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_itag,
    output lsu_wbck_i_ready,
    input  mdv_wbck_i_valid, mdv_wbck_i_wdat, mdv_wbck_i_itag,
    output mdv_wbck_i_ready,
    output longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx,
    input  longp_wbck_o_ready
  );

endinterface

// File: rtl/exu_oitf.sv
// In-order outstanding-instruction FIFO: wrap-bit pointers, entry storage and
// head fields for the long-pipe scheduler.
module exu_oitf
  import exu_longp_sched_pkg::*;
#(
  parameter int OITF_DEPTH = 4,
  parameter int ITAG_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc,
  input  oitf_entry_t        alloc_entry,
  input  logic               retire,
  output logic               full,
  output logic               empty,
  output logic [ITAG_W-1:0]  wptr_idx,
  output logic [ITAG_W-1:0]  rptr_idx,
  output oitf_entry_t        head
);

  localparam logic [ITAG_W:0] PTR_ONE = {{ITAG_W{1'b0}}, 1'b1};

  logic [ITAG_W:0] wptr_q;
  logic [ITAG_W:0] rptr_q;
  oitf_entry_t     entries_q [OITF_DEPTH];

  assign wptr_idx = wptr_q[ITAG_W-1:0];
  assign rptr_idx = rptr_q[ITAG_W-1:0];
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_idx == rptr_idx) && (wptr_q[ITAG_W] != rptr_q[ITAG_W]);
  assign head     = entries_q[rptr_idx];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (alloc)  wptr_q <= wptr_q + PTR_ONE;
      if (retire) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Entry payloads are never cleared; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (alloc) entries_q[wptr_idx] <= alloc_entry;
  end

endmodule

// File: rtl/exu_longp_sched.sv
// Long-pipe write-back scheduler: retires LSU/MULDIV results strictly in issue
// order through a one-entry registered stage toward the write-back arbiter.
module exu_longp_sched
  import exu_longp_sched_pkg::*;
#(
  parameter int OITF_DEPTH = LONGP_OITF_DEPTH,
  parameter int ITAG_W     = LONGP_ITAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  exu_longp_sched_if.slave  bus
);

  logic                    full;
  logic                    empty;
  logic [ITAG_W-1:0]       wptr_idx;
  logic [ITAG_W-1:0]       rptr_idx;
  oitf_entry_t             head;
  oitf_entry_t             alloc_entry;
  logic                    alloc;
  logic                    retire;
  logic                    out_can_load;
  logic                    head_ok;
  logic                    lsu_ready;
  logic                    mdv_ready;
  logic                    lsu_fire;
  logic                    mdv_fire;
  logic [XLEN-1:0]         sel_wdat;

  logic                    out_valid_q;
  logic [XLEN-1:0]         out_wdat_q;
  logic [RFIDX_WIDTH-1:0]  out_rdidx_q;

  assign alloc_entry = '{unit:  longp_unit_e'(bus.disp_i_unit),
                         rdwen: bus.disp_i_rdwen,
                         rdidx: bus.disp_i_rdidx};

  assign bus.disp_i_ready = ~full & ~flush_i;
  assign bus.disp_o_itag  = wptr_idx;
  assign bus.oitf_empty   = empty;
  assign alloc            = bus.disp_i_valid & bus.disp_i_ready;

  // Only the unit owning the head, presenting the head's tag, may retire.
  assign out_can_load = ~out_valid_q | bus.longp_wbck_o_ready;
  assign head_ok      = ~empty & ~flush_i & out_can_load;
  assign lsu_ready    = head_ok && (head.unit == LONGP_UNIT_LSU) &&
                        (bus.lsu_wbck_i_itag == rptr_idx);
  assign mdv_ready    = head_ok && (head.unit == LONGP_UNIT_MDV) &&
                        (bus.mdv_wbck_i_itag == rptr_idx);

  assign bus.lsu_wbck_i_ready = lsu_ready;
  assign bus.mdv_wbck_i_ready = mdv_ready;

  assign lsu_fire = lsu_ready & bus.lsu_wbck_i_valid;
  assign mdv_fire = mdv_ready & bus.mdv_wbck_i_valid;
  assign retire   = lsu_fire | mdv_fire;
  assign sel_wdat = mdv_fire ? bus.mdv_wbck_i_wdat : bus.lsu_wbck_i_wdat;

  exu_oitf #(
    .OITF_DEPTH (OITF_DEPTH),
    .ITAG_W     (ITAG_W)
  ) u_oitf (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_i),
    .alloc       (alloc),
    .alloc_entry (alloc_entry),
    .retire      (retire),
    .full        (full),
    .empty       (empty),
    .wptr_idx    (wptr_idx),
    .rptr_idx    (rptr_idx),
    .head        (head)
  );

  // Stores (rdwen = 0) pop the OITF without producing a write-back beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_wdat_q  <= '0;
      out_rdidx_q <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (retire && head.rdwen) begin
      out_valid_q <= 1'b1;
      out_wdat_q  <= sel_wdat;
      out_rdidx_q <= head.rdidx;
    end else if (bus.longp_wbck_o_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.longp_wbck_o_valid = out_valid_q;
  assign bus.longp_wbck_o_wdat  = out_wdat_q;
  assign bus.longp_wbck_o_rdidx = out_rdidx_q;

endmodule

// File: tb/tb_exu_longp_sched.sv
// Directed bench for exu_longp_sched: per-cycle vector table plus hand-written
// flush and mid-operation reset sequences.
module tb_exu_longp_sched;
  import exu_longp_sched_pkg::*;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        dv;
    logic        du;
    logic        dw;
    logic [4:0]  drd;
    logic        lv;
    logic [31:0] lw;
    logic [1:0]  lt;
    logic        mv;
    logic [31:0] mw;
    logic [1:0]  mt;
    logic        rdy;
    logic        e_dr;
    logic [1:0]  e_itag;
    logic        e_empty;
    logic        e_lr;
    logic        e_mr;
    logic        e_ov;
    logic [31:0] e_wdat;
    logic [4:0]  e_rdidx;
  } vec_t;

  localparam int NV = 29;

  logic clk;
  logic rst;
  logic flush_i;
  int   n_compared;
  int   n_mismatched;
  vec_t vecs [NV];

  exu_longp_sched_if #(.ITAG_W(2)) bus ();

  exu_longp_sched dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk_vec(
    input logic rst_v, input logic fl, input logic dv, input logic du, input logic dw,
    input logic [4:0] drd, input logic lv, input logic [31:0] lw, input logic [1:0] lt,
    input logic mv, input logic [31:0] mw, input logic [1:0] mt, input logic rdy,
    input logic edr, input logic [1:0] eit, input logic eem, input logic elr,
    input logic emr, input logic eov, input logic [31:0] ew, input logic [4:0] erd);
    vec_t r;
    r.rst = rst_v;  r.flush = fl;  r.dv = dv;  r.du = du;  r.dw = dw;  r.drd = drd;
    r.lv = lv;  r.lw = lw;  r.lt = lt;  r.mv = mv;  r.mw = mw;  r.mt = mt;  r.rdy = rdy;
    r.e_dr = edr;  r.e_itag = eit;  r.e_empty = eem;  r.e_lr = elr;  r.e_mr = emr;
    r.e_ov = eov;  r.e_wdat = ew;  r.e_rdidx = erd;
    return r;
  endfunction

  task automatic set_idle();
    rst                    = 1'b0;
    flush_i                = 1'b0;
    bus.disp_i_valid       = 1'b0;
    bus.disp_i_unit        = 1'b0;
    bus.disp_i_rdwen       = 1'b0;
    bus.disp_i_rdidx       = '0;
    bus.lsu_wbck_i_valid   = 1'b0;
    bus.lsu_wbck_i_wdat    = '0;
    bus.lsu_wbck_i_itag    = '0;
    bus.mdv_wbck_i_valid   = 1'b0;
    bus.mdv_wbck_i_wdat    = '0;
    bus.mdv_wbck_i_itag    = '0;
    bus.longp_wbck_o_ready = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst                    = v.rst;
    flush_i                = v.flush;
    bus.disp_i_valid       = v.dv;
    bus.disp_i_unit        = v.du;
    bus.disp_i_rdwen       = v.dw;
    bus.disp_i_rdidx       = v.drd;
    bus.lsu_wbck_i_valid   = v.lv;
    bus.lsu_wbck_i_wdat    = v.lw;
    bus.lsu_wbck_i_itag    = v.lt;
    bus.mdv_wbck_i_valid   = v.mv;
    bus.mdv_wbck_i_wdat    = v.mw;
    bus.mdv_wbck_i_itag    = v.mt;
    bus.longp_wbck_o_ready = v.rdy;
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Control flags packed as {dr, itag[1:0], empty, lsu_rdy, mdv_rdy, out_valid}.
  task automatic checkOutput(input string name, input vec_t v);
    check_val({name, " ctrl"},
              {57'd0, bus.disp_i_ready, bus.disp_o_itag, bus.oitf_empty,
               bus.lsu_wbck_i_ready, bus.mdv_wbck_i_ready, bus.longp_wbck_o_valid},
              {57'd0, v.e_dr, v.e_itag, v.e_empty, v.e_lr, v.e_mr, v.e_ov});
    if (v.e_ov)
      check_val({name, " data"},
                {27'd0, bus.longp_wbck_o_rdidx, bus.longp_wbck_o_wdat},
                {27'd0, v.e_rdidx, v.e_wdat});
  endtask

  task automatic disp_only(input logic unit, input logic [4:0] rd);
    set_idle();
    bus.disp_i_valid = 1'b1;
    bus.disp_i_unit  = unit;
    bus.disp_i_rdwen = 1'b1;
    bus.disp_i_rdidx = rd;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clk          = 1'b0;
    set_idle();
    rst = 1'b1;

    //            rst fl dv du dw drd  lv lw       lt  mv mw       mt  rdy | dr it em lr mr ov wdat     rd
    vecs[0]  = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,0,1,0,0,0,32'h0,   0);
    vecs[1]  = mk_vec(0,0, 1,1,1,5,   0,32'h0,   0,  0,32'h0,   0,  1,   1,0,1,0,0,0,32'h0,   0);
    vecs[2]  = mk_vec(0,0, 1,0,1,7,   0,32'h0,   0,  0,32'h0,   0,  1,   1,1,0,0,1,0,32'h0,   0);
    vecs[3]  = mk_vec(0,0, 0,0,0,0,   1,32'hAA,  1,  0,32'h0,   0,  1,   1,2,0,0,1,0,32'h0,   0);
    vecs[4]  = mk_vec(0,0, 0,0,0,0,   1,32'hAA,  1,  1,32'h55,  0,  1,   1,2,0,0,1,0,32'h0,   0);
    vecs[5]  = mk_vec(0,0, 0,0,0,0,   1,32'hAA,  1,  0,32'h0,   0,  1,   1,2,0,1,0,1,32'h55,  5);
    vecs[6]  = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,2,1,0,0,1,32'hAA,  7);
    vecs[7]  = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,2,1,0,0,0,32'h0,   0);
    vecs[8]  = mk_vec(1,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,2,1,0,0,0,32'h0,   0);
    vecs[9]  = mk_vec(0,0, 1,1,1,1,   0,32'h0,   0,  0,32'h0,   0,  1,   1,0,1,0,0,0,32'h0,   0);
    vecs[10] = mk_vec(0,0, 1,1,1,2,   0,32'h0,   0,  0,32'h0,   0,  1,   1,1,0,0,1,0,32'h0,   0);
    vecs[11] = mk_vec(0,0, 1,1,1,3,   0,32'h0,   0,  0,32'h0,   0,  1,   1,2,0,0,1,0,32'h0,   0);
    vecs[12] = mk_vec(0,0, 1,1,1,4,   0,32'h0,   0,  0,32'h0,   0,  1,   1,3,0,0,1,0,32'h0,   0);
    vecs[13] = mk_vec(0,0, 1,1,1,6,   0,32'h0,   0,  1,32'h11,  0,  1,   0,0,0,0,1,0,32'h0,   0);
    vecs[14] = mk_vec(0,0, 1,1,1,6,   0,32'h0,   0,  0,32'h0,   0,  1,   1,0,0,0,0,1,32'h11,  1);
    vecs[15] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   1,  1,   0,1,0,0,1,0,32'h0,   0);
    vecs[16] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h1000,1,  1,   0,1,0,0,1,0,32'h0,   0);
    vecs[17] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h1234,2,  1,   1,1,0,0,1,1,32'h1000,2);
    vecs[18] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h2000,3,  0,   1,1,0,0,0,1,32'h1234,3);
    vecs[19] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h2000,3,  0,   1,1,0,0,0,1,32'h1234,3);
    vecs[20] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h2000,3,  1,   1,1,0,0,1,1,32'h1234,3);
    vecs[21] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'h3000,0,  1,   1,1,0,0,1,1,32'h2000,4);
    vecs[22] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,1,1,0,0,1,32'h3000,6);
    vecs[23] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,1,1,0,0,0,32'h0,   0);
    vecs[24] = mk_vec(0,0, 1,0,0,8,   0,32'h0,   0,  0,32'h0,   0,  1,   1,1,1,0,0,0,32'h0,   0);
    vecs[25] = mk_vec(0,0, 1,1,1,10,  1,32'hDEAD,1,  0,32'h0,   0,  1,   1,2,0,1,0,0,32'h0,   0);
    vecs[26] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  1,32'hBEEF,2,  1,   1,3,0,0,1,0,32'h0,   0);
    vecs[27] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,3,1,0,0,1,32'hBEEF,10);
    vecs[28] = mk_vec(0,0, 0,0,0,0,   0,32'h0,   0,  0,32'h0,   0,  1,   1,3,1,0,0,0,32'h0,   0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("reset disp_ready", {63'd0, bus.disp_i_ready}, 64'd1);
    check_val("reset itag", {62'd0, bus.disp_o_itag}, 64'd0);
    check_val("reset empty", {63'd0, bus.oitf_empty}, 64'd1);
    check_val("reset unit readies", {62'd0, bus.lsu_wbck_i_ready, bus.mdv_wbck_i_ready}, 64'd0);
    check_val("reset out", {26'd0, bus.longp_wbck_o_valid, bus.longp_wbck_o_rdidx,
                            bus.longp_wbck_o_wdat}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Flush with three entries outstanding and a held output beat.
    @(negedge clk); disp_only(1'b1, 5'd1);
    @(negedge clk); disp_only(1'b1, 5'd2);
    @(negedge clk); disp_only(1'b1, 5'd3);
    @(negedge clk); disp_only(1'b1, 5'd4);
    bus.mdv_wbck_i_valid = 1'b1;
    bus.mdv_wbck_i_wdat  = 32'h77;
    bus.mdv_wbck_i_itag  = 2'd3;
    @(negedge clk);
    disp_only(1'b1, 5'd12);
    flush_i                = 1'b1;
    bus.longp_wbck_o_ready = 1'b0;
    bus.mdv_wbck_i_valid   = 1'b1;
    bus.mdv_wbck_i_wdat    = 32'h88;
    bus.mdv_wbck_i_itag    = 2'd0;
    #1;
    check_val("flush pre out", {26'd0, bus.longp_wbck_o_valid, bus.longp_wbck_o_rdidx,
                                bus.longp_wbck_o_wdat}, {26'd0, 1'b1, 5'd1, 32'h77});
    check_val("flush pre empty", {63'd0, bus.oitf_empty}, 64'd0);
    check_val("flush readies", {61'd0, bus.disp_i_ready, bus.lsu_wbck_i_ready,
                                bus.mdv_wbck_i_ready}, 64'd0);
    @(negedge clk);
    set_idle();
    #1;
    check_val("flush post empty", {63'd0, bus.oitf_empty}, 64'd1);
    check_val("flush post valid", {63'd0, bus.longp_wbck_o_valid}, 64'd0);
    check_val("flush post itag", {62'd0, bus.disp_o_itag}, 64'd0);

    // Reset in the middle of a pending write-back beat.
    @(negedge clk); disp_only(1'b1, 5'd9);
    @(negedge clk);
    set_idle();
    bus.mdv_wbck_i_valid = 1'b1;
    bus.mdv_wbck_i_wdat  = 32'h99;
    #1;
    check_val("mid mdv ready", {63'd0, bus.mdv_wbck_i_ready}, 64'd1);
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
    check_val("mid out before rst", {26'd0, bus.longp_wbck_o_valid, bus.longp_wbck_o_rdidx,
                                     bus.longp_wbck_o_wdat}, {26'd0, 1'b1, 5'd9, 32'h99});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("mid rst out", {26'd0, bus.longp_wbck_o_valid, bus.longp_wbck_o_rdidx,
                              bus.longp_wbck_o_wdat}, 64'd0);
    check_val("mid rst flags", {60'd0, bus.oitf_empty, bus.disp_i_ready, bus.disp_o_itag},
              {60'd0, 1'b1, 1'b1, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/exu_longp_sched.md
Name: exu_longp_sched

Overview:
Scheduler for the long-pipe write-back channel that feeds the write-back arbiter (longp_wbck_* side).
- Tracks every dispatched long-pipe instruction (LSU, MULDIV) in an in-order outstanding-instruction FIFO (OITF).
- Accepts a completion only from the unit owning the FIFO head, so long-pipe results retire strictly in issue order.
- Registers the selected result into a one-entry output stage that drives the arbiter's long-pipe port.

Parameters:
- OITF_DEPTH, 4, number of outstanding long-pipe instructions; power of 2, minimum 2.
- ITAG_W, 2, tag width; equals log2(OITF_DEPTH).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  pipeline flush; discards all outstanding entries.
- disp_i_valid  in  1  dispatch of a long-pipe instruction.
- disp_i_ready  out  1  OITF has room.
- disp_i_unit  in  1  target unit: 0 = LSU, 1 = MULDIV.
- disp_i_rdwen  in  1  instruction writes rd.
- disp_i_rdidx  in  RFIDX_WIDTH  destination register.
- disp_o_itag  out  ITAG_W  tag allocated to this dispatch (current write pointer).
- oitf_empty  out  1  no outstanding entries.
- lsu_wbck_i_valid  in  1  LSU result valid.
- lsu_wbck_i_ready  out  1  LSU result accepted.
- lsu_wbck_i_wdat  in  XLEN  LSU result data.
- lsu_wbck_i_itag  in  ITAG_W  LSU result tag.
- mdv_wbck_i_valid  in  1  MULDIV result valid.
- mdv_wbck_i_ready  out  1  MULDIV result accepted.
- mdv_wbck_i_wdat  in  XLEN  MULDIV result data.
- mdv_wbck_i_itag  in  ITAG_W  MULDIV result tag.
- longp_wbck_o_valid  out  1  registered result to the write-back arbiter.
- longp_wbck_o_ready  in  1  arbiter accepts the result.
- longp_wbck_o_wdat  out  XLEN  result data.
- longp_wbck_o_rdidx  out  RFIDX_WIDTH  result destination register.

Behaviour:
- OITF pointers: wptr and rptr, each ITAG_W+1 bits with a wrap bit.
  - empty when wptr == rptr.
  - full when the indices are equal and the wrap bits differ.
  - Each entry holds {unit, rdwen, rdidx}.
- Dispatch:
  - disp_i_ready = ~full & ~flush_i.
  - On disp_i_valid & disp_i_ready, the entry is written at wptr and wptr increments next cycle.
  - disp_o_itag = wptr index.
  - No same-cycle pass-through while full: a retire in that cycle does not free space until the next cycle.
- Head selection (combinational): a unit's ready is 1 only when all of the following hold:
  - OITF not empty, and ~flush_i.
  - head.unit matches that unit.
  - the unit's itag == rptr index.
  - the output stage can load: ~out_valid, or longp_wbck_o_ready.
  - Otherwise that unit's ready is 0. A non-head or tag-mismatched response stalls and is not an error.
- Retire: on a handshake of the selected unit, rptr increments next cycle.
  - If head.rdwen = 1: the output register loads {wdat, head.rdidx} and out_valid = 1 next cycle.
  - If head.rdwen = 0 (e.g. store): the entry is popped and nothing is written to the output stage.
- Output stage:
  - Latency is 1 cycle from the unit handshake to longp_wbck_o_valid.
  - Holds stable while valid & ~ready.
  - Clears on ready unless reloaded in the same cycle, which gives back-to-back throughput of 1 per cycle.
- Simultaneous dispatch and retire (not full): both pointers advance; occupancy is unchanged.
- Flush:
  - Next cycle: wptr = rptr = 0 and out_valid = 0.
  - Takes priority over dispatch, retire and output load in the same cycle.
  - Unit readies and disp_i_ready are 0 during flush_i.
- Reset, next clk edge with rst = 1:
  - wptr = rptr = 0, out_valid = 0, longp_wbck_o_wdat = 0, longp_wbck_o_rdidx = 0.
  - Entries are not cleared.
  - Reset mid-operation discards all in-flight state, like a flush.
- Reset values of outputs (all driven from reset state):
  - disp_i_ready = 1, disp_o_itag = 0, oitf_empty = 1.
  - lsu_wbck_i_ready = 0, mdv_wbck_i_ready = 0.
  - longp_wbck_o_valid = 0, longp_wbck_o_wdat = 0, longp_wbck_o_rdidx = 0.
- Widths: XLEN = 32 and RFIDX_WIDTH = 5, both from defines.v.

Decomposition:
- defines.v gains:
  - `LONGP_UNIT_LSU (1'b0) and `LONGP_UNIT_MDV (1'b1).
  - `OITF_DEPTH and `ITAG_WIDTH.
- Sub-module exu_oitf contains the pointer/entry FIFO (alloc, retire, flush, empty/full, head fields).
- exu_longp_sched instantiates exu_oitf and adds the head-select logic and the output register.

Test Plan:
- Reset then idle: oitf_empty = 1, disp_i_ready = 1, longp_wbck_o_valid = 0, both unit readies = 0.
- In-order retire: dispatch MULDIV rd = 5 (tag 0) and LSU rd = 7 (tag 1); LSU responds first with tag 1, data 0xAA.
  - LSU ready stays 0 while MULDIV is pending.
  - MULDIV responds with 0x55: output {0x55, rd 5}; next cycle LSU accepted, output {0xAA, rd 7}.
- Full: dispatch 4 entries → disp_i_ready = 0.
  - A fifth dispatch is blocked even in the cycle of a retire.
  - The fifth dispatch is accepted the cycle after the retire, with disp_o_itag = 0 (wrap).
- No write: LSU store with rdwen = 0.
  - Response popped (rptr advances), longp_wbck_o_valid stays 0.
  - A following MULDIV result emits normally.
- Back-pressure: hold longp_wbck_o_ready = 0 with a pending result {0x1234, rd 3}.
  - Output holds stable and the unit ready = 0.
  - Releasing ready retires one result per cycle for 3 queued results.
- Flush: flush with 3 entries outstanding and output valid.
  - Next cycle: oitf_empty = 1, longp_wbck_o_valid = 0.
  - The same-cycle dispatch and unit response are not accepted.
